ysyx_22041071_ifu: RTL and testbench

Instruction fetch unit; transmitting end of the IF->ID valid/ready interface that the decode stage consumes as PC2/Ins1/valid2/ready2.
- Owns the architectural PC and issues one outstanding request at a time to instruction memory.
- Buffers returned instructions in a small FIFO and presents them in order to ID.
- Accepts redirects from ID (jal) and EX (branch/jalr); on redirect it flushes the FIFO and any in-flight fetch.

---
 rtl/ysyx_22041071_ifu_pkg.sv | 16 +
 rtl/ysyx_22041071_ifu_fifo.sv | 59 +++++
 rtl/ysyx_22041071_ifu.sv | 161 ++++++++++++++++
 tb/tb_ysyx_22041071_ifu.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_ifu_pkg.sv
// Shared constants for the instruction fetch unit: bus widths, reset PC and
// FSM state encodings. Imported by the IFU top and its FIFO.
// Ports: none (package).
package ysyx_22041071_ifu_pkg;

  localparam int unsigned IFU_ADDR_W = 64;
  localparam int unsigned IFU_INS_W  = 32;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

  // Fetch FSM encodings
  localparam logic [1:0] IFU_IDLE = 2'd0;
  localparam logic [1:0] IFU_REQ  = 2'd1;
  localparam logic [1:0] IFU_WAIT = 2'd2;

endpackage

// File: rtl/ysyx_22041071_ifu_fifo.sv
// Purpose: synchronous FIFO with flush, used to buffer fetched {pc, ins}.
// Latency: 1 cycle push-to-head; no bypass. Backpressure: push at full is
//          accepted only together with a pop; count_o feeds request credit.
// Ports: clk, reset (sync, active-high), push_i/data_i, pop_i, flush_i,
//        head_o, empty_o, full_o, count_o.
module ysyx_22041071_ifu_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A push at full is legal only when the head leaves in the same cycle.
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ysyx_22041071_ifu.sv
// Purpose: instruction fetch unit; owns the PC, one outstanding imem request,
//          buffers responses and offers {PC2, Ins1} to ID over valid2/ready2.
// Latency: >=1 cycle from imem response to valid2. Backpressure: ready2 low
//          fills the FIFO, then imem_req_valid stays low until space frees up.
// Ports: clk/reset (sync, active-high); imem_req_* / imem_addr / imem_rsp_*;
//        PC2/Ins1/valid2/ready2 to ID; id_/ex_redirect + targets.
// Optional macro IFU_PERF_CNT_EN adds perf_fetch_cnt and perf_flush_cnt.
module ysyx_22041071_ifu
  import ysyx_22041071_ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = IFU_ADDR_W,
  parameter int unsigned       INS_W      = IFU_INS_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(IFU_RESET_PC),
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INS_W-1:0]  imem_rsp_data,
  output logic [ADDR_W-1:0] PC2,
  output logic [INS_W-1:0]  Ins1,
  output logic              valid2,
  input  logic              ready2,
  input  logic              id_redirect,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INS_W;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
  logic              drop_q, drop_d;

  logic              redirect;
  logic [ADDR_W-1:0] raw_target, redirect_pc;
  logic              in_flight, req_credit, req_fire;
  logic              rsp_in_wait, push, pop;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_cnt;

  // EX resolves older instructions than ID, so its target wins.
  assign redirect    = (id_redirect | ex_redirect) & ~reset;
  assign raw_target  = ex_redirect ? ex_target : id_target;
  assign redirect_pc = {raw_target[ADDR_W-1:2], 2'b00};

  // Every issued request owns a FIFO slot until its response lands, so the
  // response can always be pushed without overflow.
  assign in_flight  = (state_q == IFU_WAIT);
  assign req_credit = ~fifo_full &
                      ((fifo_cnt + CNT_W'(in_flight)) < CNT_W'(FIFO_DEPTH));

  assign imem_req_valid = (state_q == IFU_REQ) & req_credit & ~reset;
  assign imem_addr      = {pc_q[ADDR_W-1:2], 2'b00};
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_in_wait = (state_q == IFU_WAIT) & imem_rsp_valid & ~reset;
  assign push        = rsp_in_wait & ~drop_q & ~redirect;

  // Offer is squashed combinationally in a redirect cycle: the head is stale.
  assign valid2 = ~fifo_empty & ~(id_redirect | ex_redirect) & ~reset;
  assign pop    = valid2 & ready2;
  assign PC2    = (fifo_empty | reset) ? '0 : fifo_head[ENT_W-1:INS_W];
  assign Ins1   = (fifo_empty | reset) ? '0 : fifo_head[INS_W-1:0];

  ysyx_22041071_ifu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({issued_pc_q, imem_rsp_data}),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    drop_d      = drop_q;
    case (state_q)
      IFU_IDLE: state_d = IFU_REQ;
      IFU_REQ: begin
        if (req_fire) begin
          issued_pc_d = pc_q;
          pc_d        = pc_q + ADDR_W'(4);
          state_d     = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = IFU_REQ;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
    if (redirect) begin
      pc_d = redirect_pc;
      // Mark the outstanding fetch stale; a response landing in this very
      // cycle is already discarded via push, so no mark is needed then.
      if ((state_q == IFU_WAIT && !imem_rsp_valid) ||
          (state_q == IFU_REQ && req_fire)) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IFU_IDLE;
      pc_q        <= RESET_PC;
      issued_pc_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      drop_q      <= drop_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_q, perf_flush_q;
  logic        rsp_dropped;

  assign rsp_dropped = rsp_in_wait & (drop_q | redirect);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + 64'(pop);
      perf_flush_q <= perf_flush_q + 64'(redirect) + 64'(rsp_dropped);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_ysyx_22041071_ifu.sv
module tb_ysyx_22041071_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rsp_data;
  logic [63:0] PC2;
  logic [31:0] Ins1;
  logic        valid2, ready2;
  logic        id_redirect, ex_redirect;
  logic [63:0] id_target, ex_target;

  ysyx_22041071_ifu dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .PC2            (PC2),
    .Ins1           (Ins1),
    .valid2         (valid2),
    .ready2         (ready2),
    .id_redirect    (id_redirect),
    .id_target      (id_target),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // memory behaviour knobs (written by main only)
  int mem_fixed_delay = 1;   // 0 = random 1..3 cycles
  int mem_ready_pct   = 100;

  // event logs written by the monitor, cleared by main
  logic [63:0] acc_q[$];
  logic [63:0] hs_q[$];
  int          rsp_cyc_q[$];
  int          v_cyc_q[$];
  int          hs_total = 0;
  int          cyc = 0;

  // reference model state (monitor only)
  exp_t        exp_q[$];
  logic [63:0] exp_next;
  logic [63:0] fpc;
  logic        mon_out, prev_hold;
  logic [63:0] prev_addr;

  // memory state (memory process only)
  logic        mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr_q;

  function automatic logic [31:0] ins_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc  = exp_next;
    e.ins = ins_of(exp_next);
    exp_q.push_back(e);
    exp_next = exp_next + 64'd4;
  endtask

  // ID sees a sequential stream starting at each redirect target / reset PC.
  task automatic restart_exp(input logic [63:0] base);
    exp_q.delete();
    exp_next = base;
    for (int i = 0; i < 8; i++) push_exp();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    hs_q.delete();
    rsp_cyc_q.delete();
    v_cyc_q.delete();
  endtask

  task automatic wait_for(input int which, input int n, input int budget, input string name);
    int i;
    int sz;
    i = 0;
    sz = (which == 0) ? acc_q.size() : hs_q.size();
    while (sz < n && i < budget) begin
      step();
      i++;
      sz = (which == 0) ? acc_q.size() : hs_q.size();
    end
    n_cmp++;
    if (sz < n) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d events, required %0d", name, sz, n);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Instruction memory: one request at a time, response after a delay.
  initial begin : memory
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    mem_addr_q = '0;
    forever begin
      @(negedge clk);
      if (imem_rsp_valid) mem_busy = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        mem_busy   = 1'b1;
        mem_addr_q = imem_addr;
        mem_cnt    = (mem_fixed_delay > 0) ? mem_fixed_delay : int'($urandom_range(1, 3));
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = ins_of(mem_addr_q);
        end
      end
      imem_req_ready = (int'($urandom_range(0, 99)) < mem_ready_pct);
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    logic        redir, acc;
    logic [63:0] tgt;
    exp_t        e;
    fpc = RST_PC;
    restart_exp(RST_PC);
    mon_out = 1'b0;
    prev_hold = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("valid2_in_reset", 64'(valid2), 64'd0);
        chk("req_valid_in_reset", 64'(imem_req_valid), 64'd0);
        chk("PC2_in_reset", PC2, 64'd0);
        fpc = RST_PC;
        restart_exp(RST_PC);
        mon_out = 1'b0;
        prev_hold = 1'b0;
      end else begin
        redir = id_redirect | ex_redirect;
        tgt = ex_redirect ? ex_target : id_target;
        tgt[1:0] = 2'b00;
        acc = imem_req_valid & imem_req_ready;
        if (prev_hold) begin
          chk("req_valid_held", 64'(imem_req_valid), 64'd1);
          chk("req_addr_held", imem_addr, prev_addr);
        end
        if (redir) chk("valid2_on_redirect", 64'(valid2), 64'd0);
        if (acc) begin
          chk("single_outstanding", 64'(mon_out), 64'd0);
          chk("fetch_addr", imem_addr, fpc);
          if (acc_q.size() < 64) acc_q.push_back(imem_addr);
        end
        if (imem_rsp_valid) begin
          mon_out = 1'b0;
          if (rsp_cyc_q.size() < 16) rsp_cyc_q.push_back(cyc);
        end
        if (acc) mon_out = 1'b1;
        if (valid2 && v_cyc_q.size() < 16) v_cyc_q.push_back(cyc);
        if (valid2 && ready2) begin
          hs_total++;
          if (hs_q.size() < 64) hs_q.push_back(PC2);
          if (exp_q.size() == 0) push_exp();
          e = exp_q.pop_front();
          push_exp();
          chk("PC2", PC2, e.pc);
          chk("Ins1", 64'(Ins1), 64'(e.ins));
        end
        prev_hold = imem_req_valid & ~imem_req_ready & ~redir;
        prev_addr = imem_addr;
        if (redir) begin
          fpc = tgt;
          restart_exp(tgt);
        end else if (acc) begin
          fpc = fpc + 64'd4;
        end
      end
    end
  end

  // Stimulus
  initial begin : main
    int hs_before;
    int r;
    logic [63:0] t;
    reset = 1'b1;
    ready2 = 1'b0;
    id_redirect = 1'b0;
    ex_redirect = 1'b0;
    id_target = '0;
    ex_target = '0;
    repeat (3) step();
    chk("addr_in_reset", imem_addr, RST_PC);
    chk("Ins1_in_reset", 64'(Ins1), 64'd0);

    // sequential fetch, 1-cycle memory, ID always ready
    clear_logs();
    ready2 = 1'b1;
    reset = 1'b0;
    wait_for(1, 4, 60, "t1_deliver");
    for (int k = 0; k < 4; k++) begin
      chk("t1_fetch_seq", acc_q[k], RST_PC + 64'(4 * k));
      chk("t1_deliver_seq", hs_q[k], RST_PC + 64'(4 * k));
    end
    n_cmp++;
    if (rsp_cyc_q.size() == 0 || v_cyc_q.size() == 0) begin
      n_fail++;
      $display("FAIL t1_latency: no response or no valid2 seen");
    end else if (v_cyc_q[0] - rsp_cyc_q[0] != 1) begin
      n_fail++;
      $display("FAIL t1_latency: got %0d cycles, required 1", v_cyc_q[0] - rsp_cyc_q[0]);
    end

    // ID stalled: two entries buffered, requests stop; then drain in order
    ready2 = 1'b0;
    reset = 1'b1;
    step();
    step();
    clear_logs();
    reset = 1'b0;
    repeat (20) step();
    chk("t2_req_stalled", 64'(imem_req_valid), 64'd0);
    chk("t2_valid2", 64'(valid2), 64'd1);
    chk("t2_head_pc", PC2, RST_PC);
    chk("t2_requests", 64'(acc_q.size()), 64'd2);
    clear_logs();
    ready2 = 1'b1;
    wait_for(0, 1, 20, "t2_resume");
    chk("t2_drained", 64'(hs_q.size()), 64'd2);
    chk("t2_drain0", hs_q[0], RST_PC);
    chk("t2_drain1", hs_q[1], RST_PC + 64'd4);
    chk("t2_resume_addr", acc_q[0], RST_PC + 64'd8);

    // EX redirect while waiting on a slow response
    clear_logs();
    mem_fixed_delay = 3;
    wait_for(0, 1, 20, "t3_accept");
    ex_redirect = 1'b1;
    ex_target = 64'h0000_0000_8000_1000;
    #2;
    chk("t3_valid2_redirect_cycle", 64'(valid2), 64'd0);
    step();
    ex_redirect = 1'b0;
    clear_logs();
    wait_for(1, 1, 40, "t3_deliver");
    chk("t3_fetch_addr", acc_q[0], 64'h0000_0000_8000_1000);
    chk("t3_first_pc", hs_q[0], 64'h0000_0000_8000_1000);

    // simultaneous ID and EX redirects: EX wins
    mem_fixed_delay = 1;
    step();
    id_redirect = 1'b1;
    id_target = 64'h0000_0000_8000_0200;
    ex_redirect = 1'b1;
    ex_target = 64'h0000_0000_8000_0300;
    step();
    id_redirect = 1'b0;
    ex_redirect = 1'b0;
    clear_logs();
    wait_for(1, 1, 40, "t4_deliver");
    chk("t4_fetch_addr", acc_q[0], 64'h0000_0000_8000_0300);
    chk("t4_first_pc", hs_q[0], 64'h0000_0000_8000_0300);

    // misaligned target is word-aligned
    id_redirect = 1'b1;
    id_target = 64'h0000_0000_8000_0402;
    step();
    id_redirect = 1'b0;
    clear_logs();
    wait_for(1, 1, 40, "t5_deliver");
    chk("t5_fetch_addr", acc_q[0], 64'h0000_0000_8000_0400);
    chk("t5_first_pc", hs_q[0], 64'h0000_0000_8000_0400);

    // PC wraps past the top of the address space
    ex_redirect = 1'b1;
    ex_target = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    ex_redirect = 1'b0;
    clear_logs();
    wait_for(1, 3, 60, "t6_deliver");
    chk("t6_pc_top", hs_q[1], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_pc_wrap", hs_q[2], 64'd0);

    // reset while a fetch is outstanding; response during / right after reset
    for (int d = 1; d <= 2; d++) begin
      mem_fixed_delay = d;
      clear_logs();
      wait_for(0, 1, 20, "t7_accept");
      reset = 1'b1;
      step();
      reset = 1'b0;
      clear_logs();
      wait_for(1, 1, 40, "t7_deliver");
      chk("t7_fetch_addr", acc_q[0], RST_PC);
      chk("t7_first_pc", hs_q[0], RST_PC);
    end

    // randomized traffic against the stream model
    mem_fixed_delay = 0;
    mem_ready_pct = 70;
    hs_before = hs_total;
    for (int i = 0; i < 3000; i++) begin
      ready2 = (int'($urandom_range(0, 99)) < 60);
      r = int'($urandom_range(0, 99));
      if (int'($urandom_range(0, 7)) == 0) t = {$urandom, $urandom};
      else t = {32'h0, 32'h8000_0000 + 32'($urandom_range(0, 8191))};
      id_redirect = (r < 3) || (r == 5);
      ex_redirect = (r >= 3 && r < 6);
      id_target = t;
      ex_target = t ^ 64'h0000_0000_0000_0F0C;
      clear_logs();
      step();
    end
    id_redirect = 1'b0;
    ex_redirect = 1'b0;
    ready2 = 1'b1;
    repeat (50) step();
    chk("random_progress", 64'((hs_total - hs_before) > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
